// File: rtl/l2_cache_tag_pkg.sv
// rtl/l2_cache_tag_pkg.sv - shared types for the L2 tag stage
package l2_cache_tag_pkg;

    localparam int L2_WAYS_DFLT    = 4;
    localparam int L2_SETS_DFLT    = 256;
    localparam int CACHE_LINE_BITS = 64;
    localparam int ADDR_BITS       = 32;
    localparam int OFFSET_BITS     = 6;
    localparam int WAY_BITS        = $clog2(L2_WAYS_DFLT);
    localparam int SET_BITS        = $clog2(L2_SETS_DFLT);
    localparam int TAG_BITS        = ADDR_BITS - SET_BITS - OFFSET_BITS;

    typedef logic [TAG_BITS-1:0] l2_tag_t;
    typedef logic [WAY_BITS-1:0] l2_way_idx_t;
    typedef logic [SET_BITS-1:0] l2_set_idx_t;

    typedef struct packed {
        l2_tag_t                tag;
        l2_set_idx_t            set_idx;
        logic [OFFSET_BITS-1:0] offset;
    } l2_addr_t;

    typedef struct packed {
        logic       valid;
        logic       store;
        logic [3:0] id;
        l2_addr_t   address;
    } l2req_packet_t;

endpackage

// File: rtl/l2_cache_tag_if.sv
// rtl/l2_cache_tag_if.sv - arbiter, read-stage update and tag-stage output bundle
interface l2_cache_tag_if #(
    parameter int L2_WAYS = l2_cache_tag_pkg::L2_WAYS_DFLT,
    parameter int L2_SETS = l2_cache_tag_pkg::L2_SETS_DFLT
);
    localparam int WB = $clog2(L2_WAYS);
    localparam int SB = $clog2(L2_SETS);

    l2_cache_tag_pkg::l2req_packet_t                    l2a_request;
    logic                                               l2a_is_l2_fill;
    logic [l2_cache_tag_pkg::CACHE_LINE_BITS-1:0]       l2a_data_from_memory;

    logic [L2_WAYS-1:0]                                 l2r_update_dirty_en;
    logic [SB-1:0]                                      l2r_update_dirty_set;
    logic                                               l2r_update_dirty_value;
    logic [L2_WAYS-1:0]                                 l2r_update_tag_en;
    logic [SB-1:0]                                      l2r_update_tag_set;
    logic                                               l2r_update_tag_valid;
    l2_cache_tag_pkg::l2_tag_t                          l2r_update_tag_value;
    logic                                               l2r_update_lru_en;
    logic [WB-1:0]                                      l2r_update_lru_hit_way;

    l2_cache_tag_pkg::l2req_packet_t                    l2t_request;
    logic [L2_WAYS-1:0]                                 l2t_valid;
    l2_cache_tag_pkg::l2_tag_t [L2_WAYS-1:0]            l2t_tag;
    logic [L2_WAYS-1:0]                                 l2t_dirty;
    logic                                               l2t_is_l2_fill;
    logic [WB-1:0]                                      l2t_fill_way;
    logic [l2_cache_tag_pkg::CACHE_LINE_BITS-1:0]       l2t_data_from_memory;

    modport master (
        output l2a_request, l2a_is_l2_fill, l2a_data_from_memory,
        output l2r_update_dirty_en, l2r_update_dirty_set, l2r_update_dirty_value,
        output l2r_update_tag_en, l2r_update_tag_set, l2r_update_tag_valid, l2r_update_tag_value,
        output l2r_update_lru_en, l2r_update_lru_hit_way,
        input  l2t_request, l2t_valid, l2t_tag, l2t_dirty, l2t_is_l2_fill, l2t_fill_way,
        input  l2t_data_from_memory
    );

    modport slave (
        input  l2a_request, l2a_is_l2_fill, l2a_data_from_memory,
        input  l2r_update_dirty_en, l2r_update_dirty_set, l2r_update_dirty_value,
        input  l2r_update_tag_en, l2r_update_tag_set, l2r_update_tag_valid, l2r_update_tag_value,
        input  l2r_update_lru_en, l2r_update_lru_hit_way,
        output l2t_request, l2t_valid, l2t_tag, l2t_dirty, l2t_is_l2_fill, l2t_fill_way,
        output l2t_data_from_memory
    );

endinterface

// File: rtl/l2_cache_tag.sv
// rtl/l2_cache_tag.sv - L2 tag lookup stage with victim select; L2_PLRU_EN selects tree pseudo-LRU over round-robin
module l2_cache_tag
    import l2_cache_tag_pkg::*;
#(
    parameter int L2_WAYS = L2_WAYS_DFLT,
    parameter int L2_SETS = L2_SETS_DFLT
) (
    input  logic          clk,
    input  logic          reset,
    l2_cache_tag_if.slave bus
);
    localparam int WB = $clog2(L2_WAYS);
    localparam int SB = $clog2(L2_SETS);

    typedef logic [WB-1:0] way_t;
    typedef logic [SB-1:0] set_t;

    set_t    lk_set;
    logic    fill_acc;
    way_t    victim;
    l2_tag_t tag_rd [L2_WAYS];

    logic [L2_WAYS-1:0] valid_q [L2_SETS];
    logic [L2_WAYS-1:0] valid_d [L2_SETS];
    logic [L2_WAYS-1:0] dirty_q [L2_SETS];
    logic [L2_WAYS-1:0] dirty_d [L2_SETS];

    l2req_packet_t                l2t_request_q, l2t_request_d;
    logic [L2_WAYS-1:0]           l2t_valid_q, l2t_valid_d;
    logic [L2_WAYS-1:0]           l2t_dirty_q, l2t_dirty_d;
    l2_tag_t [L2_WAYS-1:0]        l2t_tag_q, l2t_tag_d;
    logic                         l2t_is_l2_fill_q, l2t_is_l2_fill_d;
    way_t                         l2t_fill_way_q, l2t_fill_way_d;
    logic [CACHE_LINE_BITS-1:0]   l2t_data_q, l2t_data_d;

    assign lk_set   = bus.l2a_request.address.set_idx;
    assign fill_acc = bus.l2a_request.valid && bus.l2a_is_l2_fill;

    for (genvar w = 0; w < L2_WAYS; w++) begin : gen_tag_ram
        l2_tag_t mem [L2_SETS];

        // One tag RAM per way; writes suppressed while reset is held
        always_ff @(posedge clk) begin
            if (!reset && bus.l2r_update_tag_en[w]) begin
                mem[bus.l2r_update_tag_set] <= bus.l2r_update_tag_value;
            end
        end

        assign tag_rd[w] = mem[lk_set];
    end

`ifdef L2_PLRU_EN
    localparam int NB = L2_WAYS - 1;

    logic [NB-1:0] lru_q [L2_SETS];
    logic [NB-1:0] lru_d [L2_SETS];
    logic [NB-1:0] lru_view;
    set_t          hit_set;

    function automatic logic [NB-1:0] plru_touch(input logic [NB-1:0] bits, input way_t way);
        logic [NB-1:0] r;
        int            node;
        logic          dir;
        r    = bits;
        node = 0;
        for (int lvl = 0; lvl < WB; lvl++) begin
            dir = way[WB-1-lvl];
            for (int n = 0; n < NB; n++) begin
                if (n == node) r[n] = ~dir;
            end
            node = 2 * node + 1 + (dir ? 1 : 0);
        end
        return r;
    endfunction

    function automatic way_t plru_victim(input logic [NB-1:0] bits);
        way_t v;
        int   node;
        logic dir;
        v    = '0;
        node = 0;
        for (int lvl = 0; lvl < WB; lvl++) begin
            dir = 1'b0;
            for (int n = 0; n < NB; n++) begin
                if (n == node) dir = bits[n];
            end
            v[WB-1-lvl] = dir;
            node = 2 * node + 1 + (dir ? 1 : 0);
        end
        return v;
    endfunction

    // The hit belongs to the request currently held in the read stage
    assign hit_set = l2t_request_q.address.set_idx;

    // Victim walk sees the same-cycle hit; fill touch lands after the hit
    always_comb begin
        lru_view = lru_q[lk_set];
        if (bus.l2r_update_lru_en && hit_set == lk_set) begin
            lru_view = plru_touch(lru_view, bus.l2r_update_lru_hit_way);
        end
        victim = plru_victim(lru_view);
        lru_d  = lru_q;
        if (bus.l2r_update_lru_en) begin
            lru_d[hit_set] = plru_touch(lru_q[hit_set], bus.l2r_update_lru_hit_way);
        end
        if (fill_acc) begin
            lru_d[lk_set] = plru_touch(lru_view, victim);
        end
    end

    // Tree bits per set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lru_q <= '{default: '0};
        else       lru_q <= lru_d;
    end
`else
    way_t rr_q [L2_SETS];
    way_t rr_d [L2_SETS];
    logic unused_lru;

    assign unused_lru = ^{bus.l2r_update_lru_en, bus.l2r_update_lru_hit_way};

    // Round-robin victim; counter advances only on accepted fills
    always_comb begin
        victim = rr_q[lk_set];
        rr_d   = rr_q;
        if (fill_acc) begin
            rr_d[lk_set] = rr_q[lk_set] + 1'b1;
        end
    end

    // Round-robin counter per set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rr_q <= '{default: '0};
        else       rr_q <= rr_d;
    end
`endif

    // Valid and dirty arrays take the read stage's writes
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        for (int w = 0; w < L2_WAYS; w++) begin
            if (bus.l2r_update_tag_en[w]) begin
                valid_d[bus.l2r_update_tag_set][w] = bus.l2r_update_tag_valid;
            end
            if (bus.l2r_update_dirty_en[w]) begin
                dirty_d[bus.l2r_update_dirty_set][w] = bus.l2r_update_dirty_value;
            end
        end
    end

    // Valid and dirty state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '{default: '0};
            dirty_q <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Lookup with same-cycle write bypass so the read stage never sees stale state
    always_comb begin
        l2t_request_d    = bus.l2a_request;
        l2t_is_l2_fill_d = bus.l2a_is_l2_fill;
        l2t_data_d       = bus.l2a_data_from_memory;
        l2t_fill_way_d   = victim;
        l2t_valid_d      = valid_q[lk_set];
        l2t_dirty_d      = dirty_q[lk_set];
        l2t_tag_d        = '0;
        for (int w = 0; w < L2_WAYS; w++) begin
            l2t_tag_d[w] = tag_rd[w];
            if (bus.l2r_update_tag_en[w] && bus.l2r_update_tag_set == lk_set) begin
                l2t_tag_d[w]   = bus.l2r_update_tag_value;
                l2t_valid_d[w] = bus.l2r_update_tag_valid;
            end
            if (bus.l2r_update_dirty_en[w] && bus.l2r_update_dirty_set == lk_set) begin
                l2t_dirty_d[w] = bus.l2r_update_dirty_value;
            end
        end
    end

    // Pipeline register toward the read stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l2t_request_q    <= '0;
            l2t_valid_q      <= '0;
            l2t_dirty_q      <= '0;
            l2t_tag_q        <= '0;
            l2t_is_l2_fill_q <= 1'b0;
            l2t_fill_way_q   <= '0;
            l2t_data_q       <= '0;
        end else begin
            l2t_request_q    <= l2t_request_d;
            l2t_valid_q      <= l2t_valid_d;
            l2t_dirty_q      <= l2t_dirty_d;
            l2t_tag_q        <= l2t_tag_d;
            l2t_is_l2_fill_q <= l2t_is_l2_fill_d;
            l2t_fill_way_q   <= l2t_fill_way_d;
            l2t_data_q       <= l2t_data_d;
        end
    end

    assign bus.l2t_request          = l2t_request_q;
    assign bus.l2t_valid            = l2t_valid_q;
    assign bus.l2t_dirty            = l2t_dirty_q;
    assign bus.l2t_tag              = l2t_tag_q;
    assign bus.l2t_is_l2_fill       = l2t_is_l2_fill_q;
    assign bus.l2t_fill_way         = l2t_fill_way_q;
    assign bus.l2t_data_from_memory = l2t_data_q;

endmodule

// File: tb/tb_l2_cache_tag.sv
// tb/tb_l2_cache_tag.sv - self-checking bench for l2_cache_tag
module tb_l2_cache_tag;
    import l2_cache_tag_pkg::*;

    localparam int W = L2_WAYS_DFLT;
    localparam int S = L2_SETS_DFLT;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    l2_cache_tag_if #(.L2_WAYS(W), .L2_SETS(S)) bus ();

    l2_cache_tag #(.L2_WAYS(W), .L2_SETS(S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    bit          mvalid [S][W];
    bit          mdirty [S][W];
    bit          mknown [S][W];
    l2_tag_t     mtag   [S][W];
    l2_way_idx_t mrr    [S];
    logic [2:0]  mtree  [S];
    l2_set_idx_t prev_set;

    l2req_packet_t              e_req;
    logic [W-1:0]               e_valid, e_dirty, e_known;
    l2_tag_t                    e_tag [W];
    logic                       e_fill, e_acc;
    l2_way_idx_t                e_way;
    logic [CACHE_LINE_BITS-1:0] e_data;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_touch(input logic [2:0] t, input l2_way_idx_t way);
        logic [2:0] r;
        r = t;
        case (way)
            2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
            2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
            2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
            default: begin r[0] = 1'b0; r[2] = 1'b0; end
        endcase
        return r;
    endfunction

    function automatic l2_way_idx_t ref_victim(input logic [2:0] t);
        if (!t[0]) return t[1] ? 2'd1 : 2'd0;
        return t[2] ? 2'd3 : 2'd2;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < S; s++) begin
            for (int w = 0; w < W; w++) begin
                mvalid[s][w] = 1'b0;
                mdirty[s][w] = 1'b0;
            end
            mrr[s]   = '0;
            mtree[s] = 3'b000;
        end
        prev_set = '0;
    endtask

    task automatic set_idle();
        bus.l2a_request            = '0;
        bus.l2a_is_l2_fill         = 1'b0;
        bus.l2a_data_from_memory   = '0;
        bus.l2r_update_dirty_en    = '0;
        bus.l2r_update_dirty_set   = '0;
        bus.l2r_update_dirty_value = 1'b0;
        bus.l2r_update_tag_en      = '0;
        bus.l2r_update_tag_set     = '0;
        bus.l2r_update_tag_valid   = 1'b0;
        bus.l2r_update_tag_value   = '0;
        bus.l2r_update_lru_en      = 1'b0;
        bus.l2r_update_lru_hit_way = '0;
    endtask

    task automatic make_req(input logic v, input l2_set_idx_t s, input logic f);
        l2req_packet_t p;
        p                 = '0;
        p.valid           = v;
        p.store           = 1'($urandom);
        p.id              = 4'($urandom);
        p.address.tag     = l2_tag_t'($urandom);
        p.address.set_idx = s;
        p.address.offset  = 6'($urandom);
        bus.l2a_request          = p;
        bus.l2a_is_l2_fill       = f;
        bus.l2a_data_from_memory = {$urandom, $urandom};
    endtask

    task automatic drive_random();
        make_req($urandom_range(0, 3) != 0, l2_set_idx_t'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
        bus.l2r_update_tag_en      = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
        bus.l2r_update_tag_set     = l2_set_idx_t'($urandom_range(0, 7));
        bus.l2r_update_tag_valid   = 1'($urandom);
        bus.l2r_update_tag_value   = l2_tag_t'($urandom);
        bus.l2r_update_dirty_en    = ($urandom_range(0, 2) == 0) ? W'($urandom) : '0;
        bus.l2r_update_dirty_set   = l2_set_idx_t'($urandom_range(0, 7));
        bus.l2r_update_dirty_value = 1'($urandom);
        bus.l2r_update_lru_en      = 1'($urandom);
        bus.l2r_update_lru_hit_way = l2_way_idx_t'($urandom);
    endtask

    task automatic check_outputs();
        chk("request", 64'(bus.l2t_request), 64'(e_req));
        chk("valid", 64'(bus.l2t_valid), 64'(e_valid));
        chk("dirty", 64'(bus.l2t_dirty), 64'(e_dirty));
        chk("is_fill", 64'(bus.l2t_is_l2_fill), 64'(e_fill));
        chk("data", 64'(bus.l2t_data_from_memory), 64'(e_data));
        if (e_acc) chk("fill_way", 64'(bus.l2t_fill_way), 64'(e_way));
        for (int w = 0; w < W; w++) begin
            if (e_known[w]) chk("tag", 64'(bus.l2t_tag[w]), 64'(e_tag[w]));
        end
    endtask

    // Read-stage writes commit this edge, so the lookup sees the post-write state
    task automatic cycle();
        l2_set_idx_t s, ts, ds;
        s  = bus.l2a_request.address.set_idx;
        ts = bus.l2r_update_tag_set;
        ds = bus.l2r_update_dirty_set;
        for (int w = 0; w < W; w++) begin
            if (bus.l2r_update_tag_en[w]) begin
                mtag[ts][w]   = bus.l2r_update_tag_value;
                mvalid[ts][w] = bus.l2r_update_tag_valid;
                mknown[ts][w] = 1'b1;
            end
            if (bus.l2r_update_dirty_en[w]) mdirty[ds][w] = bus.l2r_update_dirty_value;
        end
        for (int w = 0; w < W; w++) begin
            e_valid[w] = mvalid[s][w];
            e_dirty[w] = mdirty[s][w];
            e_known[w] = mknown[s][w];
            e_tag[w]   = mtag[s][w];
        end
        e_req  = bus.l2a_request;
        e_fill = bus.l2a_is_l2_fill;
        e_data = bus.l2a_data_from_memory;
        e_acc  = e_req.valid && e_fill;
`ifdef L2_PLRU_EN
        if (bus.l2r_update_lru_en) mtree[prev_set] = ref_touch(mtree[prev_set], bus.l2r_update_lru_hit_way);
        e_way = ref_victim(mtree[s]);
        if (e_acc) mtree[s] = ref_touch(mtree[s], e_way);
`else
        e_way = mrr[s];
        if (e_acc) mrr[s] = l2_way_idx_t'((int'(mrr[s]) + 1) % W);
`endif
        prev_set = s;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        reset = 1'b1;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_request", 64'(bus.l2t_request), 64'd0);
        chk("rst_valid", 64'(bus.l2t_valid), 64'd0);
        chk("rst_dirty", 64'(bus.l2t_dirty), 64'd0);
        chk("rst_is_fill", 64'(bus.l2t_is_l2_fill), 64'd0);
        chk("rst_fill_way", 64'(bus.l2t_fill_way), 64'd0);
        chk("rst_data", 64'(bus.l2t_data_from_memory), 64'd0);
        for (int w = 0; w < W; w++) chk("rst_tag", 64'(bus.l2t_tag[w]), 64'd0);
        model_reset();
        reset = 1'b0;

        set_idle();
        make_req(1'b1, 8'd5, 1'b0);
        cycle();
        chk("load5_req_valid", 64'(bus.l2t_request.valid), 64'd1);
        chk("load5_valid_ways", 64'(bus.l2t_valid), 64'd0);
        chk("load5_is_fill", 64'(bus.l2t_is_l2_fill), 64'd0);

        set_idle();
        make_req(1'b1, 8'd7, 1'b0);
        bus.l2r_update_tag_en    = 4'b0010;
        bus.l2r_update_tag_set   = 8'd7;
        bus.l2r_update_tag_valid = 1'b1;
        bus.l2r_update_tag_value = 18'h1A5;
        cycle();
        chk("tag_bypass_tag1", 64'(bus.l2t_tag[1]), 64'h1A5);
        chk("tag_bypass_valid1", 64'(bus.l2t_valid[1]), 64'd1);

        set_idle();
        make_req(1'b1, 8'd9, 1'b0);
        bus.l2r_update_dirty_en    = 4'b0001;
        bus.l2r_update_dirty_set   = 8'd9;
        bus.l2r_update_dirty_value = 1'b1;
        cycle();
        chk("dirty_bypass_set9", 64'(bus.l2t_dirty[0]), 64'd1);
        set_idle();
        make_req(1'b1, 8'd10, 1'b0);
        cycle();
        chk("dirty_other_set10", 64'(bus.l2t_dirty[0]), 64'd0);

`ifdef L2_PLRU_EN
        begin
            l2_way_idx_t seq [4];
            seq = '{2'd0, 2'd2, 2'd1, 2'd3};
            for (int i = 0; i < 4; i++) begin
                set_idle();
                make_req(1'b1, 8'd3, 1'b1);
                cycle();
                chk("plru_fill_seq", 64'(bus.l2t_fill_way), 64'(seq[i]));
            end
        end
        set_idle();
        make_req(1'b1, 8'd3, 1'b1);
        bus.l2r_update_lru_en      = 1'b1;
        bus.l2r_update_lru_hit_way = 2'd2;
        cycle();
        chk("plru_hit_then_fill", 64'(bus.l2t_fill_way), 64'd0);
`else
        for (int i = 0; i < 5; i++) begin
            set_idle();
            make_req(1'b1, 8'd0, 1'b1);
            bus.l2r_update_lru_en      = 1'b1;
            bus.l2r_update_lru_hit_way = l2_way_idx_t'($urandom);
            cycle();
            chk("rr_fill_seq", 64'(bus.l2t_fill_way), 64'(i % 4));
            set_idle();
            make_req(1'b1, 8'd0, 1'b0);
            bus.l2r_update_lru_en      = 1'b1;
            bus.l2r_update_lru_hit_way = l2_way_idx_t'($urandom);
            cycle();
        end
`endif

        for (int i = 0; i < 400; i++) begin
            drive_random();
            cycle();
        end

        drive_random();
        make_req(1'b1, l2_set_idx_t'($urandom_range(0, 7)), 1'b1);
        bus.l2r_update_tag_en   = '1;
        bus.l2r_update_dirty_en = '1;
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_request", 64'(bus.l2t_request), 64'd0);
        chk("midrst_valid", 64'(bus.l2t_valid), 64'd0);
        chk("midrst_dirty", 64'(bus.l2t_dirty), 64'd0);
        chk("midrst_is_fill", 64'(bus.l2t_is_l2_fill), 64'd0);
        chk("midrst_fill_way", 64'(bus.l2t_fill_way), 64'd0);
        chk("midrst_data", 64'(bus.l2t_data_from_memory), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        set_idle();

        for (int i = 0; i < 100; i++) begin
            drive_random();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
